// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: bundles the issue, ALU, load, register-file write and
// hazard-query signals of the write-back controller.
interface regfile_writeback_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);

  // Issue side: destination registers entering the scoreboard
  logic                     issue_valid;
  logic [4:0]               issue_rd;
  logic                     issue_ready;

  // ALU results, always accepted
  logic                     alu_valid;
  logic [4:0]               alu_rd;
  logic [XLEN-1:0]          alu_data;

  // Load results, buffered through the FIFO
  logic                     mem_valid;
  logic                     mem_ready;
  logic [4:0]               mem_rd;
  logic [XLEN-1:0]          mem_data;

  // Register-file write port
  logic                     rf_wen;
  logic [4:0]               rf_wsel;
  logic [XLEN-1:0]          rf_wdata;

  // Decode hazard queries and status
  logic [4:0]               rsel1;
  logic [4:0]               rsel2;
  logic                     busy1;
  logic                     busy2;
  logic [31:0]              pending;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     err_underflow;

  // Producer/consumer side that drives issue, results and read selects
  modport master (
    output issue_valid, issue_rd,
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output rsel1, rsel2,
    input  issue_ready, mem_ready,
    input  rf_wen, rf_wsel, rf_wdata,
    input  busy1, busy2, pending, fifo_count, err_underflow
  );

  // The write-back controller itself
  modport slave (
    input  issue_valid, issue_rd,
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  rsel1, rsel2,
    output issue_ready, mem_ready,
    output rf_wen, rf_wsel, rf_wdata,
    output busy1, busy2, pending, fifo_count, err_underflow
  );

endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU results and buffered load results onto the
// single register-file write port (ALU wins), and tracks outstanding writes
// per register with a 2-bit saturating scoreboard for decode RAW stalls.
module regfile_writeback #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  regfile_writeback_if.slave  bus
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  // Load FIFO storage and bookkeeping
  logic [XLEN-1:0] fifoData_q [DEPTH];
  logic [4:0]      fifoRd_q   [DEPTH];
  logic [PTRW-1:0] wrPtr_q, wrPtr_d;
  logic [PTRW-1:0] rdPtr_q, rdPtr_d;
  logic [CNTW-1:0] count_q, count_d;

  // Scoreboard counters and sticky underflow flag
  logic [1:0]      cnt_q [32];
  logic [1:0]      cnt_d [32];
  logic            err_q, err_d;

  // Registered write port
  logic            rfWen_q, rfWen_d;
  logic [4:0]      rfWsel_q, rfWsel_d;
  logic [XLEN-1:0] rfWdata_q, rfWdata_d;

  // Datapath helpers
  logic            fifoEmpty;
  logic            memReady;
  logic            push;
  logic            pop;
  logic            wrTake;
  logic [4:0]      wrRd;
  logic [XLEN-1:0] wrData;
  logic            wrEmit;
  logic            issueReady;
  logic            issueAccept;
  logic [31:0]     incVec;
  logic [31:0]     decVec;
  logic [31:0]     pendingVec;

  assign fifoEmpty = (count_q == '0);
  assign memReady  = rst && (count_q < FULL_CNT);
  assign push      = bus.mem_valid && memReady;
  // The head only drains when the ALU leaves the port free; a freshly pushed
  // entry is never visible to the same edge because pop looks at count_q.
  assign pop       = rst && !bus.alu_valid && !fifoEmpty;

  // Pick the result that owns the write port this edge: ALU first, then FIFO head
  always_comb begin
    wrTake = 1'b0;
    wrRd   = 5'd0;
    wrData = '0;
    if (bus.alu_valid) begin
      wrTake = 1'b1;
      wrRd   = bus.alu_rd;
      wrData = bus.alu_data;
    end else if (!fifoEmpty) begin
      wrTake = 1'b1;
      wrRd   = fifoRd_q[rdPtr_q];
      wrData = fifoData_q[rdPtr_q];
    end
  end

  // x0 results are consumed but never reach the register file or scoreboard
  assign wrEmit = rst && wrTake && (wrRd != 5'd0);

  // Advance FIFO pointers and occupancy; simultaneous push and pop keep the count
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PTRW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTRW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNTW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNTW'(1);
    end
  end

  assign issueReady  = rst && ((bus.issue_rd == 5'd0) || (cnt_q[bus.issue_rd] != 2'd3));
  assign issueAccept = bus.issue_valid && issueReady && (bus.issue_rd != 5'd0);
  assign incVec      = issueAccept ? (32'd1 << bus.issue_rd) : 32'd0;
  assign decVec      = wrEmit ? (32'd1 << wrRd) : 32'd0;

  // Update each scoreboard counter; an issue and a retirement on the same register cancel
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (incVec[i] && !decVec[i]) begin
        cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (decVec[i] && !incVec[i]) begin
        if (cnt_q[i] == 2'd0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 2'd1;
        end
      end
    end
  end

  // Next write-port values; select and data hold whenever nothing is written
  always_comb begin
    rfWen_d   = wrEmit;
    rfWsel_d  = rfWsel_q;
    rfWdata_d = rfWdata_q;
    if (wrEmit) begin
      rfWsel_d  = wrRd;
      rfWdata_d = wrData;
    end
  end

  // Derive per-register pending flags from the registered counters
  always_comb begin
    pendingVec = '0;
    for (int i = 1; i < 32; i++) begin
      pendingVec[i] = (cnt_q[i] != 2'd0);
    end
  end

  // Control state: reset clears the write port, FIFO pointers and scoreboard
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      rfWen_q   <= 1'b0;
      rfWsel_q  <= 5'd0;
      rfWdata_q <= '0;
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= 2'd0;
      end
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      rfWen_q   <= rfWen_d;
      rfWsel_q  <= rfWsel_d;
      rfWdata_q <= rfWdata_d;
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // FIFO payload storage; stale contents are harmless because the count gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      fifoData_q[wrPtr_q] <= bus.mem_data;
      fifoRd_q[wrPtr_q]   <= bus.mem_rd;
    end
  end

  assign bus.issue_ready   = issueReady;
  assign bus.mem_ready     = memReady;
  assign bus.rf_wen        = rfWen_q;
  assign bus.rf_wsel       = rfWsel_q;
  assign bus.rf_wdata      = rfWdata_q;
  assign bus.pending       = pendingVec;
  assign bus.busy1         = pendingVec[bus.rsel1];
  assign bus.busy2         = pendingVec[bus.rsel2];
  assign bus.fifo_count    = count_q;
  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed scenarios plus randomized traffic, all
// checked against a queue/array reference model of the write-back rules.
module tb_regfile_writeback;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rstN;

  // Free-running core clock
  always #5 clk = ~clk;

  regfile_writeback_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  regfile_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rstN),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } load_t;

  // Reference model state
  load_t           mq[$];
  int              mCnt[32];
  logic            mErr;
  logic            mWen;
  logic [4:0]      mWsel;
  logic [XLEN-1:0] mWdata;

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] modelPending();
    logic [31:0] p;
    p = '0;
    for (int i = 1; i < 32; i++) p[i] = (mCnt[i] != 0);
    return p;
  endfunction

  function automatic logic modelIssueReady();
    return rstN && ((bus.issue_rd == 5'd0) || (mCnt[bus.issue_rd] < 3));
  endfunction

  function automatic logic modelMemReady();
    return rstN && (mq.size() < DEPTH);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic modelEdge();
    logic            takeW;
    logic [4:0]      rd;
    logic [XLEN-1:0] d;
    logic            canIssue;
    logic            canPush;
    load_t           h;
    int              incR;
    int              decR;
    if (!rstN) begin
      mq.delete();
      foreach (mCnt[i]) mCnt[i] = 0;
      mErr = 1'b0; mWen = 1'b0; mWsel = 5'd0; mWdata = '0;
      return;
    end
    canIssue = modelIssueReady();
    canPush  = modelMemReady();
    takeW = 1'b0; rd = 5'd0; d = '0;
    if (bus.alu_valid) begin
      takeW = 1'b1; rd = bus.alu_rd; d = bus.alu_data;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      takeW = 1'b1; rd = h.rd; d = h.data;
    end
    if (bus.mem_valid && canPush) begin
      h.rd = bus.mem_rd; h.data = bus.mem_data;
      mq.push_back(h);
    end
    mWen = takeW && (rd != 5'd0);
    if (mWen) begin
      mWsel = rd; mWdata = d;
    end
    incR = (bus.issue_valid && canIssue && bus.issue_rd != 5'd0) ? int'(bus.issue_rd) : -1;
    decR = mWen ? int'(rd) : -1;
    if (incR != decR) begin
      if (incR >= 0) mCnt[incR]++;
      if (decR >= 0) begin
        if (mCnt[decR] == 0) mErr = 1'b1;
        else mCnt[decR]--;
      end
    end
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = '0;
    bus.rsel1 = 5'd0; bus.rsel2 = 5'd0;
  endtask

  task automatic test_reset();
    idle();
    rstN = 1'b0;
    tick();
    tick();
    checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_ready got=%0b exp=0", bus.mem_ready); end
    checks++; if (bus.issue_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_issue_ready got=%0b exp=0", bus.issue_ready); end
    checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("[TB] FAIL reset_wen got=%0b exp=0", bus.rf_wen); end
    checks++; if (bus.rf_wsel !== 5'd0) begin failures++; $display("[TB] FAIL reset_wsel got=%0d exp=0", bus.rf_wsel); end
    checks++; if (bus.rf_wdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_wdata got=%h exp=0", bus.rf_wdata); end
    checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", bus.fifo_count); end
    checks++; if (bus.pending !== 32'd0) begin failures++; $display("[TB] FAIL reset_pending got=%h exp=0", bus.pending); end
    checks++; if (bus.err_underflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%0b exp=0", bus.err_underflow); end
    rstN = 1'b1;
    #1;
    checks++; if (bus.mem_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_mem_ready got=%0b exp=1", bus.mem_ready); end
    checks++; if (bus.issue_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_issue_ready got=%0b exp=1", bus.issue_ready); end
  endtask

  task automatic test_alu();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    tick();
    bus.issue_valid = 1'b0; bus.rsel1 = 5'd5;
    #1;
    checks++; if (bus.busy1 !== 1'b1) begin failures++; $display("[TB] FAIL alu_busy_before got=%0b exp=1", bus.busy1); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    bus.alu_valid = 1'b0;
    checks++; if (bus.rf_wen !== 1'b1) begin failures++; $display("[TB] FAIL alu_wen got=%0b exp=1", bus.rf_wen); end
    checks++; if (bus.rf_wsel !== 5'd5) begin failures++; $display("[TB] FAIL alu_wsel got=%0d exp=5", bus.rf_wsel); end
    checks++; if (bus.rf_wdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL alu_wdata got=%h exp=deadbeef", bus.rf_wdata); end
    checks++; if (bus.busy1 !== 1'b0) begin failures++; $display("[TB] FAIL alu_busy_after got=%0b exp=0", bus.busy1); end
    checks++; if (bus.err_underflow !== 1'b0) begin failures++; $display("[TB] FAIL alu_err got=%0b exp=0", bus.err_underflow); end
    tick();
    checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("[TB] FAIL alu_wen_drop got=%0b exp=0", bus.rf_wen); end
    checks++; if (bus.rf_wsel !== 5'd5) begin failures++; $display("[TB] FAIL alu_wsel_hold got=%0d exp=5", bus.rf_wsel); end
    checks++; if (bus.rf_wdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL alu_wdata_hold got=%h exp=deadbeef", bus.rf_wdata); end
  endtask

  task automatic test_fifo_pressure();
    logic [XLEN-1:0] aluData;
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10;
    for (int k = 0; k < 5; k++) begin
      aluData = $urandom;
      bus.alu_data = aluData;
      if (k < 4) begin
        bus.mem_valid = 1'b1; bus.mem_rd = 5'(k + 1); bus.mem_data = 32'(16 + k);
      end else begin
        bus.mem_valid = 1'b0;
      end
      #1;
      if (k == 4) begin
        checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_mem_ready got=%0b exp=0", bus.mem_ready); end
        checks++; if (bus.fifo_count !== 3'd4) begin failures++; $display("[TB] FAIL full_count got=%0d exp=4", bus.fifo_count); end
      end else begin
        checks++; if (bus.mem_ready !== 1'b1) begin failures++; $display("[TB] FAIL fill_mem_ready k=%0d got=%0b exp=1", k, bus.mem_ready); end
      end
      tick();
      checks++; if (bus.rf_wen !== 1'b1 || bus.rf_wsel !== 5'd10 || bus.rf_wdata !== aluData) begin
        failures++; $display("[TB] FAIL pressure_alu k=%0d got=%0b/%0d/%h exp=1/10/%h", k, bus.rf_wen, bus.rf_wsel, bus.rf_wdata, aluData);
      end
      checks++; if (bus.fifo_count !== CW'(k < 4 ? k + 1 : 4)) begin failures++; $display("[TB] FAIL pressure_count k=%0d got=%0d", k, bus.fifo_count); end
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.rf_wen !== 1'b1 || bus.rf_wsel !== 5'(k + 1) || bus.rf_wdata !== 32'(16 + k)) begin
        failures++; $display("[TB] FAIL drain k=%0d got=%0b/%0d/%h exp=1/%0d/%h", k, bus.rf_wen, bus.rf_wsel, bus.rf_wdata, k + 1, 16 + k);
      end
      checks++; if (bus.fifo_count !== CW'(3 - k)) begin failures++; $display("[TB] FAIL drain_count k=%0d got=%0d exp=%0d", k, bus.fifo_count, 3 - k); end
    end
    tick();
    checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("[TB] FAIL drain_done_wen got=%0b exp=0", bus.rf_wen); end
  endtask

  task automatic test_saturate();
    idle();
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    for (int k = 0; k < 3; k++) tick();
    bus.rsel1 = 5'd7;
    #1;
    checks++; if (bus.issue_ready !== 1'b0) begin failures++; $display("[TB] FAIL sat_issue_ready got=%0b exp=0", bus.issue_ready); end
    checks++; if (bus.busy1 !== 1'b1) begin failures++; $display("[TB] FAIL sat_busy1 got=%0b exp=1", bus.busy1); end
    tick();
    bus.issue_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = $urandom;
      tick();
      bus.alu_valid = 1'b0;
      checks++; if (bus.issue_ready !== 1'b1) begin failures++; $display("[TB] FAIL sat_ready_after k=%0d got=%0b exp=1", k, bus.issue_ready); end
      checks++; if (bus.busy1 !== (k < 2)) begin failures++; $display("[TB] FAIL sat_busy_after k=%0d got=%0b exp=%0b", k, bus.busy1, k < 2); end
    end
    checks++; if (bus.err_underflow !== 1'b0) begin failures++; $display("[TB] FAIL sat_err got=%0b exp=0", bus.err_underflow); end
  endtask

  task automatic test_same_edge();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h0000_0909;
    tick();
    idle();
    checks++; if (bus.pending[9] !== 1'b1) begin failures++; $display("[TB] FAIL same_edge_pending got=%0b exp=1", bus.pending[9]); end
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_wsel !== 5'd9) begin failures++; $display("[TB] FAIL same_edge_write got=%0b/%0d exp=1/9", bus.rf_wen, bus.rf_wsel); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9;
    tick();
    idle();
    checks++; if (bus.pending[9] !== 1'b0) begin failures++; $display("[TB] FAIL same_edge_clear got=%0b exp=0", bus.pending[9]); end
    checks++; if (bus.err_underflow !== 1'b0) begin failures++; $display("[TB] FAIL same_edge_err got=%0b exp=0", bus.err_underflow); end
  endtask

  task automatic test_x0();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFFFFFF;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = $urandom;
    tick();
    idle();
    checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("[TB] FAIL x0_alu_wen got=%0b exp=0", bus.rf_wen); end
    checks++; if (bus.fifo_count !== 3'd1) begin failures++; $display("[TB] FAIL x0_count got=%0d exp=1", bus.fifo_count); end
    tick();
    checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("[TB] FAIL x0_mem_wen got=%0b exp=0", bus.rf_wen); end
    checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL x0_drained got=%0d exp=0", bus.fifo_count); end
    checks++; if (bus.pending !== 32'd0) begin failures++; $display("[TB] FAIL x0_pending got=%h exp=0", bus.pending); end
    checks++; if (bus.err_underflow !== 1'b0) begin failures++; $display("[TB] FAIL x0_err got=%0b exp=0", bus.err_underflow); end
  endtask

  task automatic test_reset_mid();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd20;
    for (int k = 0; k < 3; k++) begin
      bus.mem_valid = 1'b1; bus.mem_rd = 5'(11 + k); bus.mem_data = $urandom;
      tick();
      bus.issue_valid = 1'b0;
    end
    idle();
    checks++; if (bus.fifo_count !== 3'd3) begin failures++; $display("[TB] FAIL mid_count got=%0d exp=3", bus.fifo_count); end
    checks++; if (bus.pending[20] !== 1'b1) begin failures++; $display("[TB] FAIL mid_pending got=%0b exp=1", bus.pending[20]); end
    rstN = 1'b0;
    #1;
    checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_mem_ready got=%0b exp=0", bus.mem_ready); end
    tick();
    checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL mid_rst_count got=%0d exp=0", bus.fifo_count); end
    checks++; if (bus.pending !== 32'd0) begin failures++; $display("[TB] FAIL mid_rst_pending got=%h exp=0", bus.pending); end
    rstN = 1'b1;
    #1;
    checks++; if (bus.mem_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_release_ready got=%0b exp=1", bus.mem_ready); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("[TB] FAIL mid_post_wen k=%0d got=%0b exp=0", k, bus.rf_wen); end
    end
  endtask

  task automatic test_random();
    logic [31:0] p;
    for (int c = 0; c < 400; c++) begin
      rstN = ($urandom_range(0, 59) != 0);
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd    = 5'($urandom);
      bus.alu_valid   = ($urandom_range(0, 9) < 4);
      bus.alu_rd      = 5'($urandom);
      bus.alu_data    = $urandom;
      bus.mem_valid   = 1'($urandom_range(0, 1));
      bus.mem_rd      = 5'($urandom);
      bus.mem_data    = $urandom;
      bus.rsel1       = 5'($urandom);
      bus.rsel2       = 5'($urandom);
      #1;
      p = modelPending();
      checks++; if (bus.issue_ready !== modelIssueReady()) begin failures++; $display("[TB] FAIL rnd_issue_ready c=%0d got=%0b exp=%0b", c, bus.issue_ready, modelIssueReady()); end
      checks++; if (bus.mem_ready !== modelMemReady()) begin failures++; $display("[TB] FAIL rnd_mem_ready c=%0d got=%0b exp=%0b", c, bus.mem_ready, modelMemReady()); end
      checks++; if (bus.busy1 !== p[bus.rsel1] || bus.busy2 !== p[bus.rsel2]) begin
        failures++; $display("[TB] FAIL rnd_busy c=%0d got=%0b%0b exp=%0b%0b", c, bus.busy1, bus.busy2, p[bus.rsel1], p[bus.rsel2]);
      end
      checks++; if (bus.pending !== p) begin failures++; $display("[TB] FAIL rnd_pending c=%0d got=%h exp=%h", c, bus.pending, p); end
      checks++; if (bus.rf_wen !== mWen || bus.rf_wsel !== mWsel || bus.rf_wdata !== mWdata) begin
        failures++; $display("[TB] FAIL rnd_write c=%0d got=%0b/%0d/%h exp=%0b/%0d/%h", c, bus.rf_wen, bus.rf_wsel, bus.rf_wdata, mWen, mWsel, mWdata);
      end
      checks++; if (bus.fifo_count !== CW'(mq.size())) begin failures++; $display("[TB] FAIL rnd_count c=%0d got=%0d exp=%0d", c, bus.fifo_count, mq.size()); end
      checks++; if (bus.err_underflow !== mErr) begin failures++; $display("[TB] FAIL rnd_err c=%0d got=%0b exp=%0b", c, bus.err_underflow, mErr); end
      tick();
    end
  endtask

  // Hard time limit so the bench always ends even if the design wedges the clocking
  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  // Run every scenario in order and report
  initial begin
    rstN = 1'b0;
    idle();
    #1;
    test_reset();
    test_alu();
    test_fifo_pressure();
    test_saturate();
    test_same_edge();
    test_x0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
